// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, tick-based stability filter,
// debounced level, press/release pulses and a long-press detector with auto-repeat.
// The release and repeat pulse ports carry a _pulse suffix because both bare words are reserved.
module button_conditioner #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned HOLD_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int unsigned CW   = $clog2(STABLE_TICKS + 1);
    localparam int unsigned HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    // Terminal counts: counter value on the tick that completes the interval.
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_REPEAT  = 2'd2,
        S_HELD    = 2'd3
    } state_t;

    localparam state_t HOLD_NEXT = (REPEAT_TICKS > 0) ? S_REPEAT : S_HELD;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic [CW-1:0] cnt;
        logic [HW-1:0] hcnt;
        state_t        state;
        logic          lvl;
        logic          prs;
        logic          rel;
        logic          hld;
        logic          rpt;
        logic          settle_c;
        logic          rise_c;
        logic          fall_c;

        // Tick on which the filtered level flips.
        assign settle_c = enable && (sync2 != lvl) && (cnt == STABLE_LAST);
        assign rise_c   = settle_c && sync2;
        assign fall_c   = settle_c && !sync2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                cnt   <= '0;
                hcnt  <= '0;
                state <= S_IDLE;
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rel   <= 1'b0;
                hld   <= 1'b0;
                rpt   <= 1'b0;
            end else begin
                sync1 <= button[g];
                sync2 <= sync1;
                prs   <= 1'b0;
                rel   <= 1'b0;
                hld   <= 1'b0;
                rpt   <= 1'b0;

                if (enable) begin
                    if (sync2 == lvl) begin
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        lvl <= sync2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // A debounced fall pre-empts any hold or repeat due on the same tick.
                if (fall_c) begin
                    rel   <= 1'b1;
                    hcnt  <= '0;
                    state <= S_IDLE;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (rise_c) begin
                                prs   <= 1'b1;
                                hcnt  <= '0;
                                state <= S_PRESSED;
                            end
                        end
                        S_PRESSED: begin
                            if (enable) begin
                                if (hcnt == HOLD_LAST) begin
                                    hld   <= 1'b1;
                                    hcnt  <= '0;
                                    state <= HOLD_NEXT;
                                end else begin
                                    hcnt <= hcnt + HW'(1);
                                end
                            end
                        end
                        S_REPEAT: begin
                            if (enable) begin
                                if (hcnt == REPEAT_LAST) begin
                                    rpt  <= 1'b1;
                                    hcnt <= '0;
                                end else begin
                                    hcnt <= hcnt + HW'(1);
                                end
                            end
                        end
                        S_HELD: begin
                            hcnt <= hcnt;
                        end
                        default: begin
                            hcnt  <= '0;
                            state <= S_IDLE;
                        end
                    endcase
                end
            end
        end

        assign level[g]         = lvl;
        assign press[g]         = prs;
        assign release_pulse[g] = rel;
        assign hold[g]          = hld;
        assign repeat_pulse[g]  = rpt;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: table-driven press vectors plus
// hand-written bounce, gated-enable and async-reset sequences, scored against event queue.
module tb_button_conditioner;

    localparam int CH = 4;
    localparam int ST = 3;
    localparam int HT = 8;
    localparam int RT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CH-1:0] button;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] hold;
    logic [CH-1:0] repeat_pulse;

    button_conditioner #(
        .CHANNELS    (CH),
        .STABLE_TICKS(ST),
        .HOLD_TICKS  (HT),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .button       (button),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .hold         (hold),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    typedef struct {
        string         name;
        logic [CH-1:0] mask;
        int            len;
        int            n_press;
        int            n_hold;
        int            n_rep;
        int            n_rel;
    } vec_t;

    ev_t   exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_on = 1'b0;
    int    en_period = 1;
    int    obs[CH][4];
    string kname[4] = '{"press", "hold", "repeat", "release"};

    function automatic bit bitof(logic [CH-1:0] v, int c);
        logic [CH-1:0] m;
        m = CH'(1) << c;
        return |(v & m);
    endfunction

    function automatic logic [CH-1:0] pulse_vec(int k);
        case (k)
            0:       return press;
            1:       return hold;
            2:       return repeat_pulse;
            default: return release_pulse;
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(int c, int cy, int k);
        ev_t e;
        e.cyc  = cy;
        e.ch   = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Compare this edge's pulses against the expected-event queue.
    task automatic monitor();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (bitof(pulse_vec(k), c)) begin
                    int idx;
                    idx = -1;
                    obs[c][k]++;
                    foreach (exp_q[i])
                        if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].ch == c && exp_q[i].kind == k)
                            idx = i;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL sb_%s ch%0d edge %0d actual=pulse required=none", kname[k], c, cyc);
                    end else begin
                        exp_q.delete(idx);
                    end
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_%s ch%0d edge %0d actual=none required=pulse",
                         kname[exp_q[i].kind], exp_q[i].ch, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_on) monitor();
        enable = ((cyc + 1) % en_period) == 0;
    endtask

    // Expected events for a clean pulse of len clocks, driven after edge n, enable tied high.
    task automatic push_pulse(logic [CH-1:0] mask, int n, int len);
        for (int c = 0; c < CH; c++) begin
            if (bitof(mask, c) && len >= ST) begin
                int p;
                p = n + ST + 2;
                push(c, p, 0);
                push(c, p + len, 3);
                if (HT < len) push(c, p + HT, 1);
                for (int t = HT + RT; t < len; t += RT) push(c, p + t, 2);
            end
        end
    endtask

    function automatic int nth_tick(int from, int nth);
        int cnt;
        cnt = 0;
        for (int e = from; e < from + 200; e++) begin
            if (e % en_period == 0) begin
                cnt++;
                if (cnt == nth) return e;
            end
        end
        return -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[7];
        int            n;
        int            m;
        int            p;
        int            r;
        logic [4:0]    seq;

        vecs[0] = '{"short_l3",       4'b0001,  3, 1, 0, 0, 1};
        vecs[1] = '{"hold_vs_rel_l8", 4'b0010,  8, 1, 0, 0, 1};
        vecs[2] = '{"hold_l9",        4'b0100,  9, 1, 1, 0, 1};
        vecs[3] = '{"rep_vs_rel_l12", 4'b1000, 12, 1, 1, 0, 1};
        vecs[4] = '{"repeat_l21",     4'b0001, 21, 1, 1, 3, 1};
        vecs[5] = '{"two_ch_l17",     4'b1010, 17, 1, 1, 2, 1};
        vecs[6] = '{"glitch_l2",      4'b0100,  2, 0, 0, 0, 0};

        reset_n = 1'b0;
        enable  = 1'b0;
        button  = '0;
        repeat (3) @(negedge clk);
        check("reset_level",   int'(level), 0);
        check("reset_press",   int'(press), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_hold",    int'(hold), 0);
        check("reset_repeat",  int'(repeat_pulse), 0);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        repeat (2) step();

        // Table of single clean or glitchy pulses.
        foreach (vecs[v]) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < 4; k++) obs[c][k] = 0;
            step();
            n = cyc;
            push_pulse(vecs[v].mask, n, vecs[v].len);
            button = vecs[v].mask;
            for (int i = 1; i <= vecs[v].len + 12; i++) begin
                step();
                if (i == vecs[v].len) button = '0;
                if (cyc == n + ST + 1)
                    check({vecs[v].name, "_level_pre"}, int'(level), 0);
                if (cyc == n + ST + 2 && vecs[v].n_press > 0)
                    check({vecs[v].name, "_level_rise"}, int'(level), int'(vecs[v].mask));
            end
            check({vecs[v].name, "_level_end"}, int'(level), 0);
            for (int c = 0; c < CH; c++) begin
                bit in_m;
                in_m = bitof(vecs[v].mask, c);
                check($sformatf("%s_npress_ch%0d", vecs[v].name, c), obs[c][0], in_m ? vecs[v].n_press : 0);
                check($sformatf("%s_nhold_ch%0d",  vecs[v].name, c), obs[c][1], in_m ? vecs[v].n_hold : 0);
                check($sformatf("%s_nrep_ch%0d",   vecs[v].name, c), obs[c][2], in_m ? vecs[v].n_rep : 0);
                check($sformatf("%s_nrel_ch%0d",   vecs[v].name, c), obs[c][3], in_m ? vecs[v].n_rel : 0);
            end
        end

        // Bounce on ch1 (1,1,0,1,0) then an immediate clean press: filter must restart from zero.
        seq = 5'b01011;
        step();
        for (int i = 0; i < 5; i++) begin
            button[1] = seq[0];
            seq       = seq >> 1;
            step();
        end
        n = cyc;
        button[1] = 1'b1;
        push(1, n + ST + 2, 0);
        push(1, n + ST + 2 + 4, 3);
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 4) button[1] = 1'b0;
            if (cyc == n + ST + 1) check("bounce_level_low", int'(bitof(level, 1)), 0);
            if (cyc == n + ST + 2) check("bounce_then_press_level", int'(bitof(level, 1)), 1);
        end

        // Enable strobed every 4th clock on ch3.
        en_period = 4;
        step();
        n = cyc;
        button[3] = 1'b1;
        p = nth_tick(n + 3, ST);
        r = nth_tick(n + 16 + 3, ST);
        push(3, p, 0);
        push(3, r, 3);
        for (int i = 1; i <= 44; i++) begin
            step();
            if (i == 16) button[3] = 1'b0;
            if (cyc == p) check("gated_level_rise", int'(bitof(level, 3)), 1);
        end
        en_period = 1;
        repeat (2) step();

        // Async reset while ch2 is auto-repeating with the button held.
        step();
        n = cyc;
        button[2] = 1'b1;
        push(2, n + ST + 2, 0);
        push(2, n + ST + 2 + HT, 1);
        push(2, n + ST + 2 + HT + RT, 2);
        push(2, n + ST + 2 + HT + 2 * RT, 2);
        do step(); while (cyc < n + ST + 2 + HT + 2 * RT);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_repeat", int'(repeat_pulse), 0);
        check("async_rst_all", int'({level, press, hold, release_pulse}), 0);
        repeat (2) @(negedge clk);
        check("rst_held_level", int'(level), 0);
        reset_n = 1'b1;
        m = cyc;
        push(2, m + ST + 2, 0);
        push(2, m + 6 + ST + 2, 3);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cyc == m + 6) button[2] = 1'b0;
        end

        check("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
